// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the data-memory arbiter slice.
//   arb_state_e : arbiter/sequencer FSM states
//   F3_*        : RISC-V load/store funct3 encodings
//   mem_req_t   : a latched request (we, func3, addr, wdata)
// ADDR_W_MAX bounds the address field of mem_req_t; the arbiter's ADDR_W
// must not exceed it.
// -----------------------------------------------------------------------------
package dmem_pkg;

  localparam int ADDR_W_MAX = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic                  we;
    logic [2:0]            func3;
    logic [ADDR_W_MAX-1:0] addr;
    logic [31:0]           wdata;
  } mem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Request/response bundle between the two requesters (bit0 = core,
// bit1 = DMA/debug loader) and dmem_arbiter.
//   req_valid/req_ready : per-port handshake
//   req_we/func3/addr/wdata : per-port request payload
//   rsp_valid           : per-port one-cycle response pulse
//   rsp_rdata/rsp_err   : shared response data, qualified by rsp_valid
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32
);

  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [1:0]             req_we;
  logic [1:0][2:0]        req_func3;
  logic [1:0][ADDR_W-1:0] req_addr;
  logic [1:0][31:0]       req_wdata;
  logic [1:0]             rsp_valid;
  logic [31:0]            rsp_rdata;
  logic                   rsp_err;

  modport master (
    output req_valid, req_we, req_func3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_func3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_req_check.sv
// -----------------------------------------------------------------------------
// dmem_req_check
// Purely combinational legality check for one load/store request.
//   we_i    : 1 = store, 0 = load
//   func3_i : RISC-V funct3
//   addr_i  : byte address
//   err_o   : 1 when the request must not reach memory
// Loads accept B/H/W/BU/HU, stores accept B/H/W.
// Build option: define DMEM_ARB_MISALIGN_CHECK_EN to also flag misaligned
// halfword/word accesses; otherwise alignment is not examined.
// -----------------------------------------------------------------------------
module dmem_req_check
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              we_i,
  input  logic [2:0]        func3_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              err_o
);

  logic func3_bad;
  logic misalign;
  logic unused_addr_bits;

  always_comb begin
    func3_bad = 1'b1;
    case (func3_i)
      F3_B, F3_H, F3_W: func3_bad = 1'b0;
      F3_BU, F3_HU:     func3_bad = we_i;  // unsigned variants are load-only
      default:          func3_bad = 1'b1;
    endcase
  end

`ifdef DMEM_ARB_MISALIGN_CHECK_EN
  always_comb begin
    misalign = 1'b0;
    if (func3_i[1:0] == 2'b01 && addr_i[0])
      misalign = 1'b1;
    if (func3_i[1:0] == 2'b10 && addr_i[1:0] != 2'b00)
      misalign = 1'b1;
  end
`else
  assign misalign = 1'b0;
`endif

  // Only the low address bits can matter here.
  assign unused_addr_bits = ^addr_i;

  assign err_o = func3_bad | misalign;

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Two-requester arbiter and sequencer in front of a single-port data memory.
// Port 0 (core) has fixed priority; port 1 (DMA/debug) is forced through
// after MAX_WAIT consecutive denied IDLE cycles.
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   bus (slave)  : request/response bundle, see dmem_arbiter_if
//   mem_rd_en/mem_wr_en/mem_func3/mem_addr/mem_wdata : memory command,
//                  non-zero only during the single ACCESS cycle
//   mem_rdata    : combinational read data from memory
// Sequence: handshake in T, memory access in T+1, rsp_valid pulse in T+2.
// Build option: DMEM_ARB_MISALIGN_CHECK_EN (see dmem_req_check).
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int MAX_WAIT = 4,   // 1..15
  parameter int ADDR_W   = 32   // <= ADDR_W_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_arbiter_if.slave     bus,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [2:0]        mem_func3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  arb_state_e  state_q;
  mem_req_t    req_q;
  logic        err_q;
  logic        port_q;
  logic [3:0]  wait_cnt_q;
  logic [3:0]  wait_cnt_d;
  logic        mem_rd_en_q;
  logic        mem_wr_en_q;
  logic [1:0]  rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;

  logic [1:0]        grant;
  logic              sel;
  logic              sel_we;
  logic [2:0]        sel_func3;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic              chk_err;

  // Grant is combinational so ready rises in the same cycle as valid.
  // Gating with rst_n keeps ready low while reset is held.
  always_comb begin
    grant = 2'b00;
    if (rst_n && state_q == IDLE) begin
      if (bus.req_valid[1] && (!bus.req_valid[0] || wait_cnt_q == MAX_WAIT_C))
        grant = 2'b10;
      else if (bus.req_valid[0])
        grant = 2'b01;
    end
  end

  assign bus.req_ready = grant;
  assign sel           = grant[1];
  assign sel_we        = bus.req_we[sel];
  assign sel_func3     = bus.req_func3[sel];
  assign sel_addr      = bus.req_addr[sel];
  assign sel_wdata     = bus.req_wdata[sel];

  // Counter only advances in IDLE; it holds through ACCESS/RESP so a port-1
  // request waiting behind a port-0 transfer keeps its accumulated credit.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!bus.req_valid[1] || grant[1])
      wait_cnt_d = 4'd0;
    else if (state_q == IDLE && wait_cnt_q != MAX_WAIT_C)
      wait_cnt_d = wait_cnt_q + 4'd1;
  end

  dmem_req_check #(
    .ADDR_W (ADDR_W)
  ) u_check (
    .we_i    (sel_we),
    .func3_i (sel_func3),
    .addr_i  (sel_addr),
    .err_o   (chk_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_q       <= '0;
      err_q       <= 1'b0;
      port_q      <= 1'b0;
      wait_cnt_q  <= 4'd0;
      mem_rd_en_q <= 1'b0;
      mem_wr_en_q <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      case (state_q)
        IDLE: begin
          if (grant != 2'b00) begin
            req_q.we    <= sel_we;
            req_q.func3 <= sel_func3;
            req_q.addr  <= ADDR_W_MAX'(sel_addr);
            req_q.wdata <= sel_wdata;
            err_q       <= chk_err;
            port_q      <= sel;
            // Enables are registered here so they are glitch-free in ACCESS.
            mem_rd_en_q <= !chk_err && !sel_we;
            mem_wr_en_q <= !chk_err && sel_we;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          mem_rd_en_q <= 1'b0;
          mem_wr_en_q <= 1'b0;
          // Clearing the request zeroes the memory command outside ACCESS.
          req_q       <= '0;
          rsp_valid_q <= port_q ? 2'b10 : 2'b01;
          rsp_err_q   <= err_q;
          rsp_rdata_q <= (!err_q && !req_q.we) ? mem_rdata : 32'd0;
          state_q     <= RESP;
        end
        RESP: begin
          rsp_valid_q <= 2'b00;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= 32'd0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_rd_en     = mem_rd_en_q;
  assign mem_wr_en     = mem_wr_en_q;
  assign mem_func3     = req_q.func3;
  assign mem_addr      = req_q.addr[ADDR_W-1:0];
  assign mem_wdata     = req_q.wdata;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port data memory.
- Port 0 is the core load/store path; port 1 is the DMA/debug loader.
- Grants one request at a time, drives the memory rd_en/wr_en/func3/addr/wdata for exactly one cycle, and returns a registered response with rdata or an error flag.
- Fixed priority to port 0, with an anti-starvation counter guaranteeing port 1 progress.

Parameters:
- MAX_WAIT, 4: consecutive cycles port 1 may be denied while valid before it is forced to win the next grant (range 1..15).
- ADDR_W, 32: request and memory address width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-port request valid (bit0 = core, bit1 = DMA)
- req_ready  out  2  per-port request accepted this cycle
- req_we  in  2  per-port 1 = store, 0 = load
- req_func3  in  2x3  per-port RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  in  2xADDR_W  per-port byte address
- req_wdata  in  2x32  per-port store data
- rsp_valid  out  2  per-port one-cycle response pulse
- rsp_rdata  out  32  load data, shared bus; qualified by rsp_valid
- rsp_err  out  1  error flag, shared; qualified by rsp_valid
- mem_rd_en  out  1  to memory read enable
- mem_wr_en  out  1  to memory write enable
- mem_func3  out  3  to memory funct3
- mem_addr  out  ADDR_W  to memory address
- mem_wdata  out  32  to memory write data
- mem_rdata  in  32  combinational read data from memory

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- Reset values:
  - All outputs are 0, including req_ready.
  - Wait counter is 0; all request registers are 0.
- IDLE:
  - req_ready[g] = 1 only for the winning port g, and only when that port's req_valid is high. Ready is combinational from valid and state.
  - On the handshake, latch we, func3, addr, wdata and g, then go to ACCESS.
  - No valid requests: stay in IDLE.
- Arbitration:
  - Port 0 wins when valid, unless wait_cnt == MAX_WAIT and port 1 is valid; port 1 then wins.
  - wait_cnt increments each IDLE cycle where port 1 is valid and not granted, saturating at MAX_WAIT.
  - wait_cnt clears on a port-1 grant or whenever port 1 is not valid.
- Legality check, done at latch time:
  - Loads are legal with func3 in {000, 001, 010, 100, 101}.
  - Stores are legal with func3 in {000, 001, 010}.
  - Anything else sets err_q.
- ACCESS (exactly one cycle):
  - mem_func3, mem_addr and mem_wdata are driven from the latched registers.
  - If err_q is clear: mem_rd_en = !we_q and mem_wr_en = we_q. If err_q is set, both enables are 0.
  - mem_rdata is captured into rsp_rdata at the end of the cycle, loads only. For stores and errors, rsp_rdata is 0.
  - Next state is RESP.
- RESP:
  - rsp_valid[g] = 1 for one cycle and rsp_err = err_q.
  - Next state is IDLE.
  - No response backpressure: requesters must sink the pulse.
- Latency and throughput:
  - Handshake in cycle T, memory access in T+1, rsp_valid in T+2.
  - Maximum throughput is one access per 3 cycles.
- Memory outputs are 0 in IDLE and RESP. The enables are never asserted outside ACCESS.
- Simultaneous valid on both ports: exactly one grant. The loser holds its valid and its request stays stable until accepted.
- Reset mid-operation:
  - Asynchronous return to IDLE and outputs cleared immediately.
  - A store in ACCESS is aborted if rst_n falls before the clock edge.
  - No response is issued for the in-flight request.

Optional Feature:
- Macro: DMEM_ARB_MISALIGN_CHECK_EN.
- Defined: at latch time, halfword accesses (func3[1:0] = 01) with addr[0] = 1 and word accesses with addr[1:0] != 00 also set err_q. No memory enable is asserted for them, and they respond with rsp_err = 1.
- Undefined: misaligned accesses are passed to memory unmodified and rsp_err reflects only illegal func3.

Decomposition:
- Shared package dmem_pkg holds:
  - typedef enum arb_state_e {IDLE, ACCESS, RESP}
  - funct3 constants F3_B = 000, F3_H = 001, F3_W = 010, F3_BU = 100, F3_HU = 101
  - typedef struct mem_req_t {we, func3, addr, wdata}
- One sub-module, dmem_req_check: purely combinational; takes we, func3 and addr, and outputs err (legality plus optional alignment).
- The arbiter and FSM stay in dmem_arbiter.

Test Plan:
- Port 0 LW, addr 0x10, memory word 0xDEADBEEF -> req_ready[0] in T, mem_rd_en = 1 only in T+1, rsp_valid[0] in T+2 with rsp_rdata = 0xDEADBEEF and rsp_err = 0.
- Port 1 SB, addr 0x21, wdata 0x0000AB00 -> mem_wr_en = 1 and mem_func3 = 000 for one cycle, rsp_valid[1] with rsp_rdata = 0, and the byte lane is updated in memory.
- Both ports valid continuously with MAX_WAIT = 4 -> port 0 wins the first grants; port 1 is granted once wait_cnt reaches 4; the port-1 grant happens within 5 IDLE cycles of waiting.
- Load with func3 = 011 -> no mem_rd_en, rsp_valid with rsp_err = 1; a store with func3 = 100 behaves the same way.
- With DMEM_ARB_MISALIGN_CHECK_EN, LW at addr 0x102 -> rsp_err = 1 and no enable. Without the macro, the same access sees mem_rd_en = 1 and rsp_err = 0.
- Port 0 SW in flight, rst_n dropped during ACCESS before the edge -> mem_wr_en falls immediately, memory is unchanged, no rsp_valid, FSM is in IDLE after rst_n rises.
